pc_core_lane_reducer: RTL and testbench



---
 rtl/pc_core_pkg.sv | 9 +
 rtl/pc_core_result_fifo.sv | 31 +++
 rtl/pc_core_lane_reducer.sv | 141 ++++++++++++++
 tb/tb_pc_core_lane_reducer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pc_core_pkg.sv
// pc_core_pkg: result beat layout and accumulator state encoding shared by the lane reducer.
package pc_core_pkg;
  localparam int RESULT_WIDTH = 64;
  localparam int SUM_LSB = 0;
  localparam int COUNT_LSB = 32;
  localparam int OVF_BIT = 63;
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;
  typedef enum logic {IDLE, ACCUM} acc_state_e;
endpackage

// File: rtl/pc_core_result_fifo.sv
// pc_core_result_fifo: first-word fall-through result queue with an exposed occupancy count.
module pc_core_result_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  assign pop_data = mem[rd_ptr];
endmodule

// File: rtl/pc_core_lane_reducer.sv
// pc_core_lane_reducer: sums fully kept lanes over each AXI4-Stream packet and emits one
// 64-bit result beat (sum, beat count, overflow) per packet.
module pc_core_lane_reducer
  import pc_core_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH = 32,
  parameter int C_AXIS_TID_WIDTH = 1,
  parameter int C_AXIS_TDEST_WIDTH = 1,
  parameter int C_AXIS_TUSER_WIDTH = 1,
  parameter int C_RESULT_FIFO_DEPTH = 4
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic [C_AXIS_TID_WIDTH-1:0]     s_axis_tid,
  input  logic [C_AXIS_TDEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [RESULT_WIDTH-1:0]         m_axis_tdata,
  output logic [7:0]                      m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic [C_AXIS_TID_WIDTH-1:0]     m_axis_tid,
  output logic [C_AXIS_TDEST_WIDTH-1:0]   m_axis_tdest,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser
);
  localparam int W = C_ADDER_BIT_WIDTH;
  localparam int L = C_AXIS_TDATA_WIDTH / W;
  localparam int KW = W / 8;
  localparam int SW = W + $clog2(L);
  localparam int AW = W + 8;
  localparam int SBW = C_AXIS_TID_WIDTH + C_AXIS_TDEST_WIDTH + C_AXIS_TUSER_WIDTH;
  localparam int FW = RESULT_WIDTH + SBW;
  localparam int FCW = $clog2(C_RESULT_FIFO_DEPTH) + 1;
  logic accept, pop;
  logic [L-1:0] keep_mask, s1_mask;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic [C_AXIS_TDATA_WIDTH-1:0] s1_data;
  logic [SBW-1:0] s1_sb, s2_sb, sb, sb_n;
  logic [SW-1:0] lane_sum, s2_sum;
  acc_state_e state, state_n;
  logic [AW-1:0] acc, acc_n, sum_t;
  logic [15:0] cnt, cnt_n;
  logic ovf, ovf_n, pend, pend_n;
  logic [RESULT_WIDTH-1:0] res;
  logic [FW-1:0] fifo_out;
  logic [FCW-1:0] fifo_count;
  logic [FCW:0] fill;
  assign accept = s_axis_tvalid && s_axis_tready;
  assign pop = m_axis_tvalid && m_axis_tready;
  // Credit covers every packet end still in flight, including the registered push; counting the
  // concurrent pop keeps back-to-back single-beat packets at full rate.
  assign fill = {1'b0, fifo_count} + (FCW+1)'(s1_valid & s1_last) + (FCW+1)'(s2_valid & s2_last)
              + (FCW+1)'(pend) - (FCW+1)'(pop);
  assign s_axis_tready = !s_axis_areset && fill < (FCW+1)'(C_RESULT_FIFO_DEPTH);
  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < L; i++) keep_mask[i] = &s_axis_tkeep[i*KW +: KW];
  end
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < L; i++) lane_sum = lane_sum + (s1_mask[i] ? SW'(s1_data[i*W +: W]) : '0);
  end
  always_ff @(posedge s_axis_aclk) begin
    if (accept) begin
      s1_data <= s_axis_tdata;
      s1_mask <= keep_mask;
      s1_last <= s_axis_tlast;
      s1_sb <= {s_axis_tid, s_axis_tdest, s_axis_tuser};
    end
    if (s1_valid) begin
      s2_sum <= lane_sum;
      s2_last <= s1_last;
      s2_sb <= s1_sb;
    end
  end
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset)
    if (s_axis_areset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      sb <= '0;
      pend <= 1'b0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      sb <= sb_n;
      pend <= pend_n;
    end
  // Upper accumulator bits fold into the sticky overflow after every beat.
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    sb_n = sb;
    pend_n = 1'b0;
    sum_t = '0;
    if (s2_valid) begin
      sum_t = (state == IDLE ? '0 : acc) + AW'(s2_sum);
      acc_n = {{(AW-W){1'b0}}, sum_t[W-1:0]};
      ovf_n = (state == IDLE ? 1'b0 : ovf) | (|sum_t[AW-1:W]);
      cnt_n = state == IDLE ? 16'd1 : (cnt == COUNT_MAX ? cnt : cnt + 16'd1);
      sb_n = state == IDLE ? s2_sb : sb;
      pend_n = s2_last;
      state_n = s2_last ? IDLE : ACCUM;
    end
  end
  always_comb begin
    res = '0;
    res[SUM_LSB +: 32] = acc[31:0];
    res[COUNT_LSB +: 16] = cnt;
    res[OVF_BIT] = ovf;
  end
  pc_core_result_fifo #(.WIDTH(FW), .DEPTH(C_RESULT_FIFO_DEPTH)) u_fifo (
    .clk(s_axis_aclk),
    .rst(s_axis_areset),
    .push(pend),
    .push_data({sb, res}),
    .pop(pop),
    .pop_data(fifo_out),
    .count(fifo_count)
  );
  assign m_axis_tvalid = fifo_count != '0;
  assign m_axis_tdata = fifo_out[RESULT_WIDTH-1:0];
  assign {m_axis_tid, m_axis_tdest, m_axis_tuser} = fifo_out[FW-1:RESULT_WIDTH];
  assign m_axis_tkeep = '1;
  assign m_axis_tlast = 1'b1;
endmodule

// File: tb/tb_pc_core_lane_reducer.sv
// tb_pc_core_lane_reducer: random and directed packets against a per-packet arithmetic model.
module tb_pc_core_lane_reducer;
  logic clk = 1'b0, rst = 1'b1;
  logic s_axis_tvalid = 1'b0, s_axis_tready;
  logic [511:0] s_axis_tdata = '0;
  logic [63:0] s_axis_tkeep = '0;
  logic s_axis_tlast = 1'b0, s_axis_tid = 1'b0, s_axis_tdest = 1'b0, s_axis_tuser = 1'b0;
  logic m_axis_tvalid, m_axis_tready = 1'b0;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tkeep;
  logic m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser;
  int vectors = 0, miscompares = 0, accepted = 0, waits = 0, rcv = 0, rcv_base = 0;
  bit rnd_mode = 1'b0, mrdy = 1'b0, hold = 1'b0;
  logic [66:0] exp_q[$];
  logic [66:0] got, held;

  pc_core_lane_reducer dut (
    .s_axis_aclk(clk), .s_axis_areset(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tid(s_axis_tid), .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;
  always @(negedge clk) m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : mrdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result monitor: every handshake is matched in order, held results must not change.
  always @(negedge clk) begin
    #2;
    if (rst) hold = 1'b0;
    else begin
      got = {m_axis_tid, m_axis_tdest, m_axis_tuser, m_axis_tdata};
      if (hold) begin
        chk("hold_valid", m_axis_tvalid, 1);
        chk("hold_data", got, held);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        rcv++;
        if (exp_q.size() == 0) chk("pending_expect", exp_q.size(), 1);
        else chk("result", got, exp_q.pop_front());
        chk("keep_last", {m_axis_tkeep, m_axis_tlast}, 9'h1FF);
      end
      hold = m_axis_tvalid && !m_axis_tready;
      held = got;
    end
  end

  task automatic beat(input logic [511:0] d, input logic [63:0] k, input bit l, input logic [2:0] sb);
    bit ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tkeep = k;
    s_axis_tlast = l;
    {s_axis_tid, s_axis_tdest, s_axis_tuser} = sb;
    for (int c = 0; c < 1000 && !ok; c++) begin
      #1 ok = s_axis_tready;
      if (!ok) waits++;
      @(negedge clk);
    end
    chk("accept", ok, 1);
    if (ok) accepted++;
  endtask

  // kind: 0 random data/keep, 1 lanes of 1, 2 lanes of 0x10 with only lane 0 on the last beat,
  // 3 all-ones lanes. Expected result is computed from the whole-packet total.
  task automatic send_pkt(input int n, input int kind);
    logic [511:0] d;
    logic [63:0] k;
    logic [2:0] sb0;
    longint unsigned tot;
    int r;
    sb0 = 3'($urandom);
    tot = 0;
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < 16; i++)
        d[i*32 +: 32] = kind == 1 ? 32'd1 : kind == 2 ? 32'h10 : kind == 3 ? 32'hFFFF_FFFF : $urandom;
      r = $urandom_range(0, 3);
      k = (kind == 0 && r == 1) ? '0 : (kind == 0 && r == 3) ? {$urandom, $urandom} : '1;
      if (kind == 0 && r == 2) for (int i = 0; i < 16; i++) k[i*4 +: 4] = {4{1'($urandom)}};
      if (kind == 2 && b == n - 1) k = 64'h000F;
      for (int i = 0; i < 16; i++) if (k[i*4 +: 4] == 4'hF) tot += 64'(d[i*32 +: 32]);
      beat(d, k, b == n - 1, b == 0 ? sb0 : 3'($urandom));
    end
    s_axis_tvalid = 1'b0;
    exp_q.push_back({sb0, tot >= 64'h1_0000_0000, 15'd0, 16'(n), 32'(tot)});
  endtask

  task automatic drain;
    for (int c = 0; c < 500 && (exp_q.size() != 0 || m_axis_tvalid); c++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    rst = 1'b0;
    #1 chk("s_tready_after_rst", s_axis_tready, 1);
    mrdy = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(1, 1);
    repeat (2) @(negedge clk);
    chk("latency_t2", m_axis_tvalid, 0);
    @(negedge clk);
    chk("latency_t3", m_axis_tvalid, 1);
    drain();
    send_pkt(3, 2);
    drain();
    send_pkt(2, 3);
    send_pkt(1, 1);
    drain();
    mrdy = 1'b0;
    repeat (2) @(negedge clk);
    accepted = 0;
    fork
      for (int p = 0; p < 6; p++) send_pkt(1, 0);
      begin
        repeat (20) @(negedge clk);
        chk("bp_accepted", accepted, 4);
        chk("bp_s_tready", s_axis_tready, 0);
        mrdy = 1'b1;
      end
    join
    drain();
    waits = 0;
    rcv_base = rcv;
    for (int p = 0; p < 100; p++) send_pkt(1, 0);
    chk("tp_stalls", waits, 0);
    drain();
    chk("tp_results", rcv - rcv_base, 100);
    mrdy = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt(1, 0);
    beat({16{32'h7}}, '1, 1'b0, 3'd5);
    beat({16{32'h9}}, '1, 1'b0, 3'd2);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_tvalid", m_axis_tvalid, 0);
    chk("midrst_s_tready", s_axis_tready, 0);
    exp_q.delete();
    rst = 1'b0;
    #1 chk("midrst_release_tready", s_axis_tready, 1);
    chk("midrst_release_tvalid", m_axis_tvalid, 0);
    mrdy = 1'b1;
    @(negedge clk);
    send_pkt(1, 1);
    drain();
    rnd_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_pkt($urandom_range(1, 6), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rnd_mode = 1'b0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
